// File: rtl/rx_soft_demapper.sv
// rtl/rx_soft_demapper.sv - soft-decision demapper, one LLR per cycle for BPSK/QPSK/16-QAM
// Optional hard-decision output o_hard_bit when DEMAP_HARD_DEC_EN is defined.
module rx_soft_demapper #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 14,
   parameter int QAM_THR    = 10362
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_i_sample,
   input  logic [DATA_WIDTH-1:0] i_q_sample,
   input  logic [1:0]            i_mod,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_llr,
   output logic                  o_last
`ifdef DEMAP_HARD_DEC_EN
   ,
   output logic                  o_hard_bit
`endif
);

   localparam logic [1:0] MOD_BPSK = 2'b00;
   localparam logic [1:0] MOD_QPSK = 2'b01;
   localparam logic [1:0] MOD_RSVD = 2'b11;

   localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // The threshold is a sub-unity amplitude; clip anything at or above 1.0.
   localparam int THR_LIM = (QAM_THR < (1 << FRAC_BITS)) ? QAM_THR : (1 << FRAC_BITS) - 1;
   localparam logic [DATA_WIDTH:0] THR_X = (DATA_WIDTH+1)'(THR_LIM);

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [1:0]            mod_q, mod_d;
   logic [DATA_WIDTH-1:0] i_samp_q, i_samp_d;
   logic [DATA_WIDTH-1:0] q_samp_q, q_samp_d;
   logic [DATA_WIDTH-1:0] llr_q, llr_d;
   logic                  last_q, last_d;
   logic                  in_xfer, in_ok, out_xfer;

   function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH:0] x);
      if (x[DATA_WIDTH] != x[DATA_WIDTH-1])
         return x[DATA_WIDTH] ? MIN_V : MAX_V;
      return x[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
      if (x == MIN_V)
         return MAX_V;
      return x[DATA_WIDTH-1] ? -x : x;
   endfunction

   function automatic logic [1:0] last_idx(input logic [1:0] md);
      case (md)
         MOD_BPSK: return 2'd0;
         MOD_QPSK: return 2'd1;
         default:  return 2'd3;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] llr_of(input logic [1:0]            idx,
                                                    input logic [DATA_WIDTH-1:0] si,
                                                    input logic [DATA_WIDTH-1:0] sq,
                                                    input logic [1:0]            md);
      logic [DATA_WIDTH:0] ext;
      case (idx)
         2'd0: begin
            if (md == MOD_BPSK)
               ext = {si[DATA_WIDTH-1], si} + {sq[DATA_WIDTH-1], sq};
            else
               ext = {si[DATA_WIDTH-1], si};
         end
         2'd1:    ext = {sq[DATA_WIDTH-1], sq};
         2'd2:    ext = THR_X - {1'b0, abs_sat(si)};
         default: ext = THR_X - {1'b0, abs_sat(sq)};
      endcase
      return sat(ext);
   endfunction

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (out_xfer && last_q)
         state_d = S_IDLE;
      if (in_ok)
         state_d = S_EMIT;
   end

   // Output logic
   always_comb begin
      o_valid = (state_q == S_EMIT);
      o_ready = (state_q == S_IDLE) | ((state_q == S_EMIT) & i_ready & last_q);
   end

   assign in_xfer  = i_valid & o_ready;
   assign in_ok    = in_xfer & (i_mod != MOD_RSVD);
   assign out_xfer = o_valid & i_ready;

   // Datapath: b0 from the live sample, later bits from the captured registers.
   always_comb begin
      cnt_d    = cnt_q;
      mod_d    = mod_q;
      i_samp_d = i_samp_q;
      q_samp_d = q_samp_q;
      llr_d    = llr_q;
      last_d   = last_q;
      if (out_xfer) begin
         if (last_q) begin
            cnt_d  = 2'd0;
            llr_d  = '0;
            last_d = 1'b0;
         end else begin
            cnt_d  = 2'(cnt_q + 2'd1);
            llr_d  = llr_of(2'(cnt_q + 2'd1), i_samp_q, q_samp_q, mod_q);
            last_d = (2'(cnt_q + 2'd1) == last_idx(mod_q));
         end
      end
      if (in_ok) begin
         cnt_d    = 2'd0;
         mod_d    = i_mod;
         i_samp_d = i_i_sample;
         q_samp_d = i_q_sample;
         llr_d    = llr_of(2'd0, i_i_sample, i_q_sample, i_mod);
         last_d   = (i_mod == MOD_BPSK);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q    <= 2'd0;
         mod_q    <= MOD_BPSK;
         i_samp_q <= '0;
         q_samp_q <= '0;
         llr_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         mod_q    <= mod_d;
         i_samp_q <= i_samp_d;
         q_samp_q <= q_samp_d;
         llr_q    <= llr_d;
         last_q   <= last_d;
      end
   end

   assign o_llr  = llr_q;
   assign o_last = last_q;

`ifdef DEMAP_HARD_DEC_EN
   logic hard_bit_q, hard_bit_d;

   assign hard_bit_d = llr_d[DATA_WIDTH-1];

   always_ff @(posedge i_clk) begin
      if (i_rst)
         hard_bit_q <= 1'b0;
      else
         hard_bit_q <= hard_bit_d;
   end

   assign o_hard_bit = hard_bit_q;
`endif

endmodule

// File: tb/tb_rx_soft_demapper.sv
// tb/tb_rx_soft_demapper.sv - scoreboard bench for rx_soft_demapper
module tb_rx_soft_demapper;

   logic               clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_valid = 1'b0;
   logic               o_ready;
   logic signed [15:0] i_i_sample = '0;
   logic signed [15:0] i_q_sample = '0;
   logic [1:0]         i_mod = 2'b00;
   logic               o_valid;
   logic               i_ready = 1'b1;
   logic signed [15:0] o_llr;
   logic               o_last;
`ifdef DEMAP_HARD_DEC_EN
   logic               o_hard_bit;
`endif

   typedef struct {
      int llr;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   track_en = 1'b0;
   int   run_len = 0;
   int   max_run = 0;
   int   bad_ready = 0;
   bit   rnd_done = 1'b0;

   rx_soft_demapper dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_i_sample (i_i_sample),
      .i_q_sample (i_q_sample),
      .i_mod      (i_mod),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_llr      (o_llr),
      .o_last     (o_last)
`ifdef DEMAP_HARD_DEC_EN
      ,
      .o_hard_bit (o_hard_bit)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int sat16(input int x);
      if (x > 32767)  return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic int abs16(input int x);
      if (x == -32768) return 32767;
      return (x < 0) ? -x : x;
   endfunction

   function automatic void push_exp(input int md, input int si, input int sq);
      case (md)
         0: exp_q.push_back('{sat16(si + sq), 1'b1});
         1: begin
            exp_q.push_back('{si, 1'b0});
            exp_q.push_back('{sq, 1'b1});
         end
         2: begin
            exp_q.push_back('{si, 1'b0});
            exp_q.push_back('{sq, 1'b0});
            exp_q.push_back('{sat16(10362 - abs16(si)), 1'b0});
            exp_q.push_back('{sat16(10362 - abs16(sq)), 1'b1});
         end
         default: ;
      endcase
   endfunction

   // Scoreboard consumer: compare each accepted LLR against the model.
   always @(negedge clk) begin
      if (!i_rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_llr", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("llr", int'(o_llr), e.llr);
            check("last", int'(o_last), int'(e.last));
`ifdef DEMAP_HARD_DEC_EN
            check("hard_bit", int'(o_hard_bit), (e.llr < 0) ? 1 : 0);
`endif
         end
      end
      if (track_en) begin
         run_len = o_valid ? run_len + 1 : 0;
         if (run_len > max_run) max_run = run_len;
         if (o_ready && o_valid && !(o_last && i_ready)) bad_ready++;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer, leaving i_valid high.
   task automatic send(input int md, input int si, input int sq);
      bit ok;
      ok = 1'b0;
      i_valid    = 1'b1;
      i_mod      = 2'(md);
      i_i_sample = 16'(si);
      i_q_sample = 16'(sq);
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (o_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("send_timeout", 0, 1);
      end else begin
         @(posedge clk);
         push_exp(md, si, sq);
         #1;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      check("rst_valid", int'(o_valid), 0);
      check("rst_llr", int'(o_llr), 0);
      check("rst_last", int'(o_last), 0);
      check("rst_ready", int'(o_ready), 1);
      @(posedge clk); #1;

      // QPSK with explicit idle after the last LLR
      send(1, 11585, -11585);
      i_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("qpsk_idle_after", int'(o_valid), 0);
      @(posedge clk); #1;

      // 16-QAM directed, including the most-negative I
      send(2, -5181, 15543);
      i_valid = 1'b0;
      drain();
      send(2, -32768, 15543);
      i_valid = 1'b0;
      drain();

      // BPSK saturation both ways
      send(0, 32767, 32767);
      send(0, -32768, -32768);
      i_valid = 1'b0;
      drain();

      // Three back-to-back QPSK symbols
      run_len = 0; max_run = 0; bad_ready = 0; track_en = 1'b1;
      send(1, 1000, -2000);
      send(1, -3000, 4000);
      send(1, 5000, -6000);
      i_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      track_en = 1'b0;
      check("b2b_valid_run", max_run, 6);
      check("b2b_ready_only_on_last", bad_ready, 0);
      drain();

      // Backpressure while b1 is presented
      send(2, -5181, 15543);
      i_valid = 1'b0;
      @(posedge clk); #1;
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_llr_frozen", int'(o_llr), 15543);
         check("bp_last_frozen", int'(o_last), 0);
         check("bp_ready_low", int'(o_ready), 0);
      end
      @(posedge clk); #1;
      i_ready = 1'b1;
      drain();

      // Reserved modulation when idle
      send(3, 1234, 5678);
      i_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rsvd_no_valid", int'(o_valid), 0);
      end
      @(posedge clk); #1;

      // Reset while b2 of a 16-QAM symbol is presented
      send(2, 7000, -9000);
      i_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mrst_valid", int'(o_valid), 0);
      check("mrst_llr", int'(o_llr), 0);
      check("mrst_ready", int'(o_ready), 1);
      @(posedge clk); #1;
      send(1, -1111, 2222);
      i_valid = 1'b0;
      drain();

      // Random symbols against random downstream backpressure
      fork
         begin
            for (int n = 0; n < 40; n++)
               send(int'($urandom_range(0, 3)), int'($signed(16'($urandom))),
                    int'($signed(16'($urandom))));
            i_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               if (!rnd_done) i_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      i_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rx_soft_demapper.md
# rx_soft_demapper

Receive-side soft-decision demapper for the NB-IoT uplink PHY. It is the inverse of the TX constellation mapper. It accepts one equalised complex symbol (I/Q, signed fixed point) per handshake and serialises the per-bit log-likelihood ratios (LLRs) for BPSK, QPSK or 16-QAM, one LLR per cycle, toward the descrambler. Bit order and constellation follow TS 36.211 §7.1.

## Interface
- `DATA_WIDTH`, 16, width of I/Q samples and of `o_llr`; signed two's complement.
- `FRAC_BITS`, 14, fractional bits of the I/Q format.
- `QAM_THR`, 10362, 16-QAM amplitude threshold 2/√10 in the I/Q format (round(0.632456·2^FRAC_BITS)).

- `i_clk`, in, 1, clock; all logic is rising-edge.
- `i_rst`, in, 1, synchronous active-high reset.
- `i_valid`, in, 1, input symbol valid.
- `o_ready`, out, 1, demapper can accept a symbol.
- `i_i_sample`, in, `DATA_WIDTH`, in-phase sample, signed.
- `i_q_sample`, in, `DATA_WIDTH`, quadrature sample, signed.
- `i_mod`, in, 2, modulation: 00 BPSK, 01 QPSK, 10 16-QAM, 11 reserved.
- `o_valid`, out, 1, `o_llr` valid.
- `i_ready`, in, 1, downstream accepts LLR.
- `o_llr`, out, `DATA_WIDTH`, signed LLR; positive means bit 0 more likely.
- `o_last`, out, 1, last LLR of the current symbol.

## Operation
- Handshake rules:
  - Input transfer when `i_valid & o_ready`.
  - Output transfer when `o_valid & i_ready`.
- `i_i_sample`, `i_q_sample` and `i_mod` are captured on the input transfer. Later changes to the inputs do not affect the symbol in flight.
- Bits per symbol N: BPSK 1, QPSK 2, 16-QAM 4. The bit counter runs 0..N-1.
- States:
  - IDLE: `o_valid`=0, `o_ready`=1.
  - EMIT: `o_valid`=1. The counter advances only on an output transfer. EMIT goes to IDLE on the transfer of bit N-1, unless a new symbol is accepted in the same cycle; in that case it stays in EMIT with the counter at 0.
- `o_ready` = IDLE | (`o_valid` & `i_ready` & `o_last`). This is combinational from `i_ready`.
- LLR equations, all saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]:
  - BPSK: b0 = sat(I+Q), using a DATA_WIDTH+1 internal sum.
  - QPSK: b0 = I, b1 = Q.
  - 16-QAM: b0 = I, b1 = Q, b2 = `QAM_THR`−|I|, b3 = `QAM_THR`−|Q|.
  - |x| of the most-negative value saturates to 2^(DATA_WIDTH-1)-1.
- `o_last` = 1 exactly when the counter equals N-1 while in EMIT.
- Reserved `i_mod`=11: the symbol is accepted and dropped. No LLR is emitted and the state does not change.
- Backpressure: while `o_valid & ~i_ready`, `o_llr`, `o_last` and the counter hold stable.

## Timing
- Reset values:
  - `o_valid`=0, `o_llr`=0, `o_last`=0.
  - State IDLE, counter 0, so `o_ready`=1.
- Latency: the LLR for b0 is registered and appears on `o_llr` in the cycle after the input transfer.
- Outputs are registered. b0 is computed from the incoming sample, and b1..b3 from the captured sample registers.
- Throughput with `i_ready`=1: back-to-back symbols produce a continuous `o_valid` stream with no bubbles.
- Reset asserted mid-symbol: pending LLRs are discarded and all outputs take reset values on the next edge.

## Configuration
- `DEMAP_HARD_DEC_EN`:
  - Defined: an extra output `o_hard_bit` (1 bit, registered) is added, aligned with `o_llr`. It is 1 when the LLR is negative and 0 otherwise. Its reset value is 0.
  - Undefined: the port and its logic are absent, and soft LLR behaviour is unchanged.

## Test plan
- QPSK, I=11585, Q=−11585, `i_ready`=1 → cycle+1: `o_llr`=11585, `o_last`=0; cycle+2: `o_llr`=−11585, `o_last`=1; cycle+3: `o_valid`=0.
- 16-QAM, I=−5181, Q=15543 → LLR sequence −5181, 15543, 5181, −5181, with `o_last` on the 4th. Repeat with I=−32768 → b0=−32768, b2=−22405.
- BPSK, I=Q=32767 → `o_llr`=32767 (saturated). I=Q=−32768 → `o_llr`=−32768. `o_last`=1 on each.
- Three back-to-back QPSK symbols with `i_valid`=1 and `i_ready`=1 → `o_valid` high for 6 consecutive cycles, and `o_ready` high only in the cycles where `o_last` transfers.
- 16-QAM with `i_ready` low for 3 cycles while b1 is presented → `o_llr`/`o_last` stay frozen, `o_ready`=0, then b2 and b3 follow normally. A reserved `i_mod`=11 sent when idle → no `o_valid`.
- `i_rst` pulsed while b2 of a 16-QAM symbol is presented → next cycle `o_valid`=0, `o_llr`=0, `o_ready`=1, and the next symbol starts at b0.
